// File: rtl/chiplib_arb_pri_drain.sv
// chiplib_arb_pri_drain
// Show-ahead drain FIFO that sits behind a pipelined priority arbiter.
// The arbiter has no backpressure input, so almost_full throttles the
// requesters early enough (Headroom slots) for grants already in flight
// to land. A push that still arrives while full is dropped and recorded
// in the sticky overflow flag.
//
// Optional feature: define CHIPLIB_ARB_PRI_DRAIN_STATS_EN to build a
// saturating 16-bit drop counter; without it drop_count is tied to zero.
//
// Handshake: the input side is valid-only (in_valid, no ready). The output
// side is valid/ready: a pop happens on a rising clk edge where
// out_valid && out_ready; out_pri/out_payload are held while out_valid is
// high and out_ready is low.

module chiplib_arb_pri_drain #(
    parameter int Depth         = 8,
    parameter int NumPriorities = 5,
    parameter int PayloadWidth  = 30,
    parameter int Headroom      = 3,
    localparam int PriorityWidth = $clog2(NumPriorities),
    localparam int CountWidth    = $clog2(Depth + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PriorityWidth-1:0] in_pri,
    input  logic [PayloadWidth-1:0]  in_payload,
    output logic                     almost_full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PriorityWidth-1:0] out_pri,
    output logic [PayloadWidth-1:0]  out_payload,
    output logic [CountWidth-1:0]    count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_count
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int EntryWidth = PriorityWidth + PayloadWidth;

    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    // Storage carries no reset: occupancy alone decides what is valid.
    logic [EntryWidth-1:0] r_mem [Depth];

    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [CountWidth-1:0] r_count;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [PtrWidth-1:0]   w_wr_ptr_next;
    logic [PtrWidth-1:0]   w_rd_ptr_next;
    logic [31:0]           w_free;
    logic [EntryWidth-1:0] w_head;

    // Full with a simultaneous pop still accepts the push: the pop frees
    // the slot in the same edge the tail is written.
    assign w_full = (r_count == FullCount);
    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    // Pointers wrap explicitly at Depth-1 so any Depth works.
    assign w_wr_ptr_next = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;

    // Throttle computed from the registered count only.
    assign w_free      = 32'(Depth) - 32'(r_count);
    assign almost_full = (w_free <= 32'(Headroom));

    assign w_head      = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign out_pri     = w_head[EntryWidth-1:PayloadWidth];
    assign out_payload = w_head[PayloadWidth-1:0];
    assign count       = r_count;
    assign overflow    = r_overflow;

    // Tail write of the accepted entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pri, in_payload};
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef CHIPLIB_ARB_PRI_DRAIN_STATS_EN
    logic [15:0] r_drop_count;

    // Saturating drop counter; clear with a simultaneous drop leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (ovf_clr) begin
            r_drop_count <= '0;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_chiplib_arb_pri_drain.sv
// tb_chiplib_arb_pri_drain
// Directed bench for chiplib_arb_pri_drain. Two instances: Depth=8 /
// Headroom=3 for the main sequence and Depth=5 / Headroom=1 for the
// non-power-of-two wrap sequence. Expected entries are queued when a push
// is accepted by the bench model and popped when the DUT completes a pop.

module tb_chiplib_arb_pri_drain;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic [2:0]  in_pri;
    logic [29:0] in_payload;
    logic        almost_full;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_pri;
    logic [29:0] out_payload;
    logic [3:0]  count;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] drop_count;

    logic        in_valid5;
    logic [2:0]  in_pri5;
    logic [29:0] in_payload5;
    logic        almost_full5;
    logic        out_valid5;
    logic        out_ready5;
    logic [2:0]  out_pri5;
    logic [29:0] out_payload5;
    logic [2:0]  count5;
    logic        overflow5;
    logic        ovf_clr5;
    logic [15:0] drop_count5;

    logic [32:0] exp_q[$];
    logic        m_ovf;
    int          m_drops;
    int          n_vec;
    int          n_err;

`ifdef CHIPLIB_ARB_PRI_DRAIN_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    chiplib_arb_pri_drain #(
        .Depth(8), .NumPriorities(5), .PayloadWidth(30), .Headroom(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_pri(in_pri), .in_payload(in_payload),
        .almost_full(almost_full),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pri(out_pri), .out_payload(out_payload),
        .count(count), .overflow(overflow), .ovf_clr(ovf_clr),
        .drop_count(drop_count)
    );

    chiplib_arb_pri_drain #(
        .Depth(5), .NumPriorities(5), .PayloadWidth(30), .Headroom(1)
    ) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_pri(in_pri5), .in_payload(in_payload5),
        .almost_full(almost_full5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .out_pri(out_pri5), .out_payload(out_payload5),
        .count(count5), .overflow(overflow5), .ovf_clr(ovf_clr5),
        .drop_count(drop_count5)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all status outputs of the selected instance with the model.
    task automatic check_status(input int sel);
        int sz;
        int hr;
        sz = exp_q.size();
        hr = (sel == 8) ? 3 : 1;
        if (sel == 8) begin
            check("count", 64'(count), 64'(sz));
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            check("almost_full", 64'(almost_full), 64'((8 - sz) <= hr));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("drop_count", 64'(drop_count), StatsEn ? 64'(m_drops) : 64'd0);
        end else begin
            check("count5", 64'(count5), 64'(sz));
            check("out_valid5", 64'(out_valid5), 64'(sz != 0));
            check("almost_full5", 64'(almost_full5), 64'((5 - sz) <= hr));
            check("overflow5", 64'(overflow5), 64'(m_ovf));
            check("drop_count5", 64'(drop_count5), StatsEn ? 64'(m_drops) : 64'd0);
        end
    endtask

    // Drive one cycle on the selected instance (other idles), score any pop,
    // update the model, and return at the following falling edge.
    task automatic step(input int sel, input logic v, input logic [2:0] p,
                        input logic [29:0] d, input logic rdy, input logic clr);
        logic        ov;
        logic [32:0] head;
        logic [32:0] exp;
        logic        full;
        logic        pop;
        logic        drop;
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        in_valid5 = 1'b0; out_ready5 = 1'b0; ovf_clr5 = 1'b0;
        if (sel == 8) begin
            in_valid = v; in_pri = p; in_payload = d; out_ready = rdy; ovf_clr = clr;
            ov = out_valid; head = {out_pri, out_payload};
        end else begin
            in_valid5 = v; in_pri5 = p; in_payload5 = d; out_ready5 = rdy; ovf_clr5 = clr;
            ov = out_valid5; head = {out_pri5, out_payload5};
        end
        full = (exp_q.size() == sel);
        pop  = ov && rdy;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("pop_on_empty", 64'(ov), 64'd0);
            end else begin
                exp = exp_q.pop_front();
                check("head", 64'(head), 64'(exp));
            end
        end
        drop = v && full && !pop;
        if (v && !drop) exp_q.push_back({p, d});
        if (drop) begin
            m_ovf = 1'b1;
            m_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : m_drops);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_ovf = 1'b0; m_drops = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_pri = '0; in_payload = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        in_valid5 = 1'b0; in_pri5 = '0; in_payload5 = '0; out_ready5 = 1'b0; ovf_clr5 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        check_status(8);
        check_status(5);
        check("rst_almost_full", 64'(almost_full), 64'd0);

        // Release reset and push on the very first cycle; 5 pushes, no pops.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(8, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom), 1'b0, 1'b0);
            check_status(8);
        end
        check("count_5", 64'(count), 64'd5);
        check("af_at_5", 64'(almost_full), 64'd1);

        step(8, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom), 1'b0, 1'b0);
        check("count_6", 64'(count), 64'd6);

        // Fill to 8, then hold in_valid 3 more cycles: three drops.
        for (int i = 0; i < 2; i++) begin
            step(8, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom), 1'b0, 1'b0);
        end
        check("count_full", 64'(count), 64'd8);
        check("overflow_pre", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(8, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom), 1'b0, 1'b0);
            check_status(8);
        end
        check("count_drop", 64'(count), 64'd8);
        check("overflow_set", 64'(overflow), 64'd1);
        check("drops_3", 64'(drop_count), StatsEn ? 64'd3 : 64'd0);

        // Full with push and pop every cycle: no drop, order kept across wrap.
        for (int i = 0; i < 20; i++) begin
            step(8, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom), 1'b1, 1'b0);
            check_status(8);
        end
        check("count_stream", 64'(count), 64'd8);
        check("drops_stream", 64'(drop_count), StatsEn ? 64'd3 : 64'd0);

        // Clear together with a drop: drop wins.
        step(8, 1'b1, 3'd1, 30'h1234567, 1'b0, 1'b1);
        check_status(8);
        check("ovf_clr_drop", 64'(overflow), 64'd1);
        check("drops_clr_drop", 64'(drop_count), StatsEn ? 64'd1 : 64'd0);
        step(8, 1'b0, 3'd0, 30'd0, 1'b0, 1'b1);
        check_status(8);
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Two pops to reach count 6, held output while not ready.
        step(8, 1'b0, 3'd0, 30'd0, 1'b1, 1'b0);
        step(8, 1'b0, 3'd0, 30'd0, 1'b1, 1'b0);
        step(8, 1'b0, 3'd0, 30'd0, 1'b0, 1'b0);
        check_status(8);
        check("count_6b", 64'(count), 64'd6);
        check("hold_head", 64'({out_pri, out_payload}), 64'(exp_q[0]));

        // Asynchronous reset mid-operation, one cycle long.
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_count", 64'(count), 64'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(8, 1'b1, 3'd4, 30'h2AAAAAAA, 1'b0, 1'b0);
        check_status(8);
        check("post_rst_pri", 64'(out_pri), 64'd4);
        check("post_rst_payload", 64'(out_payload), 64'h2AAAAAAA);
        step(8, 1'b0, 3'd0, 30'd0, 1'b1, 1'b0);
        check_status(8);

        // Ready while empty is a no-op.
        step(8, 1'b0, 3'd0, 30'd0, 1'b1, 1'b0);
        check_status(8);

        // Depth 5: 12 pushes with random ready, then drain; pointers wrap.
        exp_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        for (int i = 0; i < 12; i++) begin
            step(5, 1'b1, 3'($urandom_range(0, 4)), 30'($urandom),
                 (exp_q.size() >= 4) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
            check_status(5);
        end
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) begin
                step(5, 1'b0, 3'd0, 30'd0, 1'b1, 1'b0);
                check_status(5);
            end
        end
        check("d5_drained", 64'(count5), 64'd0);
        check("d5_no_ovf", 64'(overflow5), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chiplib_arb_pri_drain.md
CHIPLIB_ARB_PRI_DRAIN -- requirements
Module: chiplib_arb_pri_drain

Interface
REQ-001 SHALL have parameter Depth, default 8, meaning buffer entries; legal range 2..256, any integer, not restricted to powers of two.
REQ-002 SHALL have parameter NumPriorities, default 5, meaning priority levels carried; PriorityWidth = $clog2(NumPriorities) as a localparam.
REQ-003 SHALL have parameter PayloadWidth, default 30, meaning payload bits per entry.
REQ-004 SHALL have parameter Headroom, default 3, meaning free slots reserved for in-flight arbiter pipeline grants; legal range 0..Depth-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: winner valid from the upstream pipelined priority arbiter; valid-only, no ready.
REQ-008 SHALL have port in_pri, input, PriorityWidth bits: winner priority.
REQ-009 SHALL have port in_payload, input, PayloadWidth bits: winner payload.
REQ-010 SHALL have port almost_full, output, 1 bit: throttle to the upstream requesters.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accept.
REQ-013 SHALL have port out_pri, output, PriorityWidth bits: head priority.
REQ-014 SHALL have port out_payload, output, PayloadWidth bits: head payload.
REQ-015 SHALL have port count, output, $clog2(Depth+1) bits: current occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.
REQ-017 SHALL have port ovf_clr, input, 1 bit: synchronous clear for overflow.
REQ-018 SHALL have port drop_count, output, 16 bits: number of dropped pushes.

Function
REQ-019 SHALL be a show-ahead FIFO: out_valid = (count != 0); out_pri and out_payload SHALL come from the head entry with zero added latency; entries SHALL leave in arrival order.
REQ-020 SHALL complete a pop when out_valid && out_ready; head advances the next cycle.
REQ-021 SHALL store {in_pri, in_payload} at the tail when in_valid and the FIFO is not full, or when it is full and a pop occurs in the same cycle; the entry is visible at the head at the earliest one cycle after the push.
REQ-022 SHALL drop the push when in_valid is high, count == Depth and no pop occurs in that cycle; count SHALL be unchanged and overflow SHALL be set the next cycle.
REQ-023 SHALL update count as +1 for a push only, -1 for a pop only, and unchanged for push+pop in the same cycle or for neither.
REQ-024 SHALL wrap the read and write pointers from Depth-1 to 0; there SHALL be no power-of-two assumption.
REQ-025 SHALL compute almost_full = (Depth - count) <= Headroom as a combinational function of registered count.
REQ-026 SHALL clear overflow on ovf_clr; a drop in the same cycle as ovf_clr SHALL win, leaving overflow = 1.
REQ-027 SHALL hold out_pri and out_payload stable while out_valid && !out_ready; their values are don't-care when out_valid = 0.
REQ-028 SHALL permit out_ready high while empty; this is a no-op.

Reset
REQ-029 SHALL, while rst_n = 0, force count = 0, both pointers = 0, out_valid = 0, overflow = 0, drop_count = 0, and almost_full = (Headroom >= Depth ? 1 : 0), which evaluates to 0 for legal parameters.
REQ-030 SHALL discard all stored entries on reset mid-operation; the storage array SHALL need no reset.
REQ-031 SHALL accept a push in the first cycle after rst_n deasserts.

Configuration
REQ-032 SHALL, with macro CHIPLIB_ARB_PRI_DRAIN_STATS_EN defined, increment drop_count on every dropped push, saturating at 16'hFFFF; ovf_clr SHALL also clear drop_count, with the same drop-wins rule as REQ-026 so the result is 1.
REQ-033 SHALL, without CHIPLIB_ARB_PRI_DRAIN_STATS_EN, tie drop_count to 0 and generate no counter logic; overflow behaviour SHALL be unchanged.

Verification
REQ-034 SHALL cover: Depth=8, Headroom=3; push 5 entries with out_ready=0 -> count=5, almost_full=1; push 1 more -> count=6.
REQ-035 SHALL cover: fill to 8 and hold in_valid with out_ready=0 for 3 cycles -> count=8, overflow=1, drop_count=3 with STATS_EN, 0 without.
REQ-036 SHALL cover: full, with in_valid and out_ready high for 20 cycles -> count stays 8, no drop, output order matches input order across pointer wrap.
REQ-037 SHALL cover: Depth=5; 12 pushes interleaved with random out_ready -> pointers wrap 4->0 and the payload sequence is preserved.
REQ-038 SHALL cover: assert rst_n=0 for 1 cycle with count=6 -> out_valid=0 and count=0 immediately (asynchronous); a push the next cycle appears at the head with its pri/payload intact.
REQ-039 SHALL cover: overflow=1, with ovf_clr and a drop in the same cycle -> overflow=1 and drop_count=1 (STATS_EN).
